// File: rtl/mem_port_arbiter.sv
// Two-requester single-port RAM arbiter: load/store normally beats instruction fetch,
// but a bounded streak guarantees fetch progress; read responses are tagged by an owner FSM.
module mem_port_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 32,
  parameter int MAX_LS_STREAK = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  // instruction fetch port
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  // load/store port
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  // RAM port
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam int SW = (MAX_LS_STREAK < 1) ? 1 : $clog2(MAX_LS_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          streak_full;
  logic          if_gnt, ls_gnt;

  assign streak_full = (streak_q == STREAK_MAX);

  // Gating with reset_n keeps the combinational outputs quiet while reset is held.
  assign ls_gnt = reset_n && ls_req_i && !(streak_full && if_req_i);
  assign if_gnt = reset_n && if_req_i && !if_flush_i && (!ls_req_i || streak_full);

  assign if_gnt_o = if_gnt;
  assign ls_gnt_o = ls_gnt;

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (ls_gnt) begin
      ram_en_o    = 1'b1;
      ram_we_o    = ls_we_i;
      ram_addr_o  = ls_addr_i;
      ram_wdata_o = ls_wdata_i;
    end else if (if_gnt) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = if_addr_i;
    end
  end

  // The streak only counts while a fetch is actually waiting.
  always_comb begin
    streak_d = streak_q;
    if (!if_req_i || if_gnt) begin
      streak_d = '0;
    end else if (ls_gnt && !streak_full) begin
      streak_d = streak_q + SW'(1);
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (if_gnt) begin
      state_d = ST_FETCH;
    end else if (ls_gnt && !ls_we_i) begin
      state_d = ST_LOAD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // A flush arriving in the response cycle discards the returning instruction word.
  assign if_rvalid_o = reset_n && (state_q == ST_FETCH) && !if_flush_i;
  assign ls_rvalid_o = reset_n && (state_q == ST_LOAD);
  assign if_rdata_o  = if_rvalid_o ? ram_rdata_i : '0;
  assign ls_rdata_o  = ls_rvalid_o ? ram_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention/streak, store, flush and
// mid-read reset, with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk;
  logic          reset_n;
  logic          if_req, if_flush, ls_req, ls_we;
  logic [AW-1:0] if_addr, ls_addr;
  logic [DW-1:0] ls_wdata, ram_rdata;
  logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid;
  logic [DW-1:0] if_rdata, ls_rdata, ram_wdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;

  int tests_run = 0;
  int tests_failed = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LS_STREAK(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_flush_i (if_flush),
    .if_gnt_o   (if_gnt),
    .if_rvalid_o(if_rvalid),
    .if_rdata_o (if_rdata),
    .ls_req_i   (ls_req),
    .ls_we_i    (ls_we),
    .ls_addr_i  (ls_addr),
    .ls_wdata_i (ls_wdata),
    .ls_gnt_o   (ls_gnt),
    .ls_rvalid_o(ls_rvalid),
    .ls_rdata_o (ls_rdata),
    .ram_en_o   (ram_en),
    .ram_we_o   (ram_we),
    .ram_addr_o (ram_addr),
    .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests_run++;
    assert (obs === exp_v)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".if_gnt"}, 64'(if_gnt), 64'd0);
    chk({tag, ".ls_gnt"}, 64'(ls_gnt), 64'd0);
    chk({tag, ".if_rvalid"}, 64'(if_rvalid), 64'd0);
    chk({tag, ".ls_rvalid"}, 64'(ls_rvalid), 64'd0);
    chk({tag, ".ram_en"}, 64'(ram_en), 64'd0);
    chk({tag, ".ram_we"}, 64'(ram_we), 64'd0);
    chk({tag, ".ram_addr"}, 64'(ram_addr), 64'd0);
    chk({tag, ".ram_wdata"}, 64'(ram_wdata), 64'd0);
    chk({tag, ".if_rdata"}, 64'(if_rdata), 64'd0);
    chk({tag, ".ls_rdata"}, 64'(ls_rdata), 64'd0);
  endtask

  // Contention table: rows 0-7 both requesting, then a cycle without if_req resets the streak.
  bit t_ifreq [16] = '{1,1,1,1,1,1,1,1, 1,1,0,1,1,1,1,0};
  bit t_lsreq [16] = '{1,1,1,1,1,1,1,1, 1,1,1,1,1,1,1,0};
  bit e_if    [16] = '{0,0,0,1,0,0,0,1, 0,0,0,0,0,0,1,0};
  bit e_ls    [16] = '{1,1,1,0,1,1,1,0, 1,1,1,1,1,1,0,0};

  initial begin
    bit p_if, p_ls;
    logic [DW-1:0] rd;

    reset_n = 1'b0; if_req = 1'b0; if_flush = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; ram_rdata = 32'h1111_1111;

    // Requests held during reset must not be granted.
    nxt();
    if_req = 1'b1; ls_req = 1'b1; if_addr = 16'h0010; ls_addr = 16'h0020; ls_wdata = 32'h77;
    #1;
    chk_idle_outputs("reset");
    $display("[TB] reset with requests held: outputs quiet");
    nxt();
    if_req = 1'b0; ls_req = 1'b0; if_addr = '0; ls_addr = '0; ls_wdata = '0;
    @(negedge clk);
    reset_n = 1'b1;

    // Single fetch
    nxt();
    if_req = 1'b1; if_addr = 16'h0004;
    #1;
    chk("fetch.if_gnt", 64'(if_gnt), 64'd1);
    chk("fetch.ls_gnt", 64'(ls_gnt), 64'd0);
    chk("fetch.ram_en", 64'(ram_en), 64'd1);
    chk("fetch.ram_we", 64'(ram_we), 64'd0);
    chk("fetch.ram_addr", 64'(ram_addr), 64'h0004);
    nxt();
    if_req = 1'b0; ram_rdata = 32'h0050_0093;
    #1;
    chk("fetch.if_rvalid", 64'(if_rvalid), 64'd1);
    chk("fetch.if_rdata", 64'(if_rdata), 64'h0050_0093);
    chk("fetch.ls_rvalid", 64'(ls_rvalid), 64'd0);
    chk("fetch.ram_en_after", 64'(ram_en), 64'd0);
    $display("[TB] fetch 0x0004 -> rdata %h", if_rdata);

    // Contention with loads from 0x0100 and fetches from 0x0008
    p_if = 1'b0; p_ls = 1'b0;
    ls_we = 1'b0; ls_addr = 16'h0100; ls_wdata = 32'h55; if_addr = 16'h0008;
    for (int r = 0; r < 16; r++) begin
      nxt();
      if_req = t_ifreq[r]; ls_req = t_lsreq[r];
      rd = 32'hA000_0000 + 32'(r);
      ram_rdata = rd;
      #1;
      chk($sformatf("row%0d.if_gnt", r), 64'(if_gnt), 64'(e_if[r]));
      chk($sformatf("row%0d.ls_gnt", r), 64'(ls_gnt), 64'(e_ls[r]));
      chk($sformatf("row%0d.ram_en", r), 64'(ram_en), 64'(e_if[r] | e_ls[r]));
      chk($sformatf("row%0d.ram_addr", r), 64'(ram_addr),
          e_ls[r] ? 64'h0100 : (e_if[r] ? 64'h0008 : 64'h0));
      chk($sformatf("row%0d.ram_wdata", r), 64'(ram_wdata), e_ls[r] ? 64'h55 : 64'h0);
      chk($sformatf("row%0d.if_rvalid", r), 64'(if_rvalid), 64'(p_if));
      chk($sformatf("row%0d.ls_rvalid", r), 64'(ls_rvalid), 64'(p_ls));
      chk($sformatf("row%0d.if_rdata", r), 64'(if_rdata), p_if ? 64'(rd) : 64'h0);
      chk($sformatf("row%0d.ls_rdata", r), 64'(ls_rdata), p_ls ? 64'(rd) : 64'h0);
      $display("[TB] row %0d if_req=%0d ls_req=%0d -> if_gnt=%0d ls_gnt=%0d", r,
               if_req, ls_req, if_gnt, ls_gnt);
      p_if = e_if[r]; p_ls = e_ls[r];
    end

    // Store
    nxt();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0200; ls_wdata = 32'hDEAD_BEEF;
    #1;
    chk("store.ls_gnt", 64'(ls_gnt), 64'd1);
    chk("store.ram_we", 64'(ram_we), 64'd1);
    chk("store.ram_addr", 64'(ram_addr), 64'h0200);
    chk("store.ram_wdata", 64'(ram_wdata), 64'hDEAD_BEEF);
    nxt();
    ls_req = 1'b0; ls_we = 1'b0; ram_rdata = 32'h1234_5678;
    #1;
    chk("store.ls_rvalid", 64'(ls_rvalid), 64'd0);
    chk("store.ls_rdata", 64'(ls_rdata), 64'd0);
    $display("[TB] store 0x0200 <- deadbeef, no load response");

    // Flush in the response cycle, then a fetch blocked by flush while a load proceeds
    if_req = 1'b1; if_addr = 16'h0008;
    #1;
    chk("flush.if_gnt", 64'(if_gnt), 64'd1);
    nxt();
    if_req = 1'b0; if_flush = 1'b1; ram_rdata = 32'hCAFE_0001;
    #1;
    chk("flush.if_rvalid", 64'(if_rvalid), 64'd0);
    chk("flush.if_rdata", 64'(if_rdata), 64'd0);
    nxt();
    if_req = 1'b1; if_flush = 1'b1;
    #1;
    chk("flush.blocked_if_gnt", 64'(if_gnt), 64'd0);
    chk("flush.blocked_ram_en", 64'(ram_en), 64'd0);
    ls_req = 1'b1; ls_addr = 16'h0300;
    #1;
    chk("flush.ls_gnt", 64'(ls_gnt), 64'd1);
    chk("flush.ls_ram_addr", 64'(ram_addr), 64'h0300);
    nxt();
    if_req = 1'b0; if_flush = 1'b0; ls_req = 1'b0; ram_rdata = 32'h0BAD_F00D;
    #1;
    chk("flush.ls_rvalid", 64'(ls_rvalid), 64'd1);
    chk("flush.ls_rdata", 64'(ls_rdata), 64'h0BAD_F00D);
    $display("[TB] flush drops fetch response, load unaffected");

    // Reset asserted while a load response is due
    ls_req = 1'b1; ls_addr = 16'h0100;
    #1;
    chk("rst.ls_gnt", 64'(ls_gnt), 64'd1);
    nxt();
    ls_req = 1'b1; if_req = 1'b1; if_addr = 16'h0040; ram_rdata = 32'h5A5A_5A5A;
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("rstmid");
    nxt();
    ls_req = 1'b0; if_addr = 16'h0000;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst.first_if_gnt", 64'(if_gnt), 64'd1);
    chk("rst.first_ram_en", 64'(ram_en), 64'd1);
    chk("rst.first_ram_addr", 64'(ram_addr), 64'h0000);
    chk("rst.ls_rvalid", 64'(ls_rvalid), 64'd0);
    nxt();
    if_req = 1'b0; ram_rdata = 32'h0000_0013;
    #1;
    chk("rst.if_rvalid", 64'(if_rvalid), 64'd1);
    chk("rst.if_rdata", 64'(if_rdata), 64'h13);
    $display("[TB] reset mid-read: response dropped, fetch 0x0000 granted after release");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning RAM address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning RAM data width in bits.
REQ-003 The block SHALL have parameter MAX_LS_STREAK, default 3, meaning the maximum consecutive load/store grants while a fetch waits.
REQ-004 The block SHALL have port clk  input  1  clock, rising edge.
REQ-005 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have ports if_req  input  1  fetch request; if_addr  input  ADDR_W  fetch address; if_flush  input  1  discard fetch in flight (jump taken).
REQ-007 The block SHALL have ports if_gnt  output  1  fetch granted this cycle; if_rvalid  output  1  fetch data valid; if_rdata  output  DATA_W  fetch data.
REQ-008 The block SHALL have ports ls_req  input  1; ls_we  input  1  1=store; ls_addr  input  ADDR_W; ls_wdata  input  DATA_W.
REQ-009 The block SHALL have ports ls_gnt  output  1; ls_rvalid  output  1  load data valid; ls_rdata  output  DATA_W.
REQ-010 The block SHALL have ports ram_en  output  1; ram_we  output  1; ram_addr  output  ADDR_W; ram_wdata  output  DATA_W; ram_rdata  input  DATA_W  read data, 1-cycle latency.

Function
REQ-011 The block SHALL grant at most one requester per cycle; if_gnt and ls_gnt SHALL never be high together.
REQ-012 Grants SHALL be combinational from current requests and registered state; a request is accepted in the cycle its gnt is high, and the requester SHALL hold req/addr/data stable until then.
REQ-013 Priority: ls_req wins over if_req, except when streak == MAX_LS_STREAK and if_req=1, in which case the fetch SHALL be granted.
REQ-014 A fetch SHALL NOT be granted in a cycle with if_flush=1; ls arbitration is unaffected by if_flush.
REQ-015 streak (width clog2(MAX_LS_STREAK+1)) SHALL increment on an ls grant while if_req=1, saturate at MAX_LS_STREAK, clear on an if grant, and clear in any cycle with if_req=0.
REQ-016 With a grant, ram_en=1 and ram_addr/ram_we/ram_wdata SHALL come from the granted requester (ram_we=0 and ram_wdata=0 for fetch); with no grant, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-017 A registered owner FSM SHALL record the read issued: states IDLE (no read last cycle), FETCH (fetch read last cycle), LOAD (ls read with ls_we=0 last cycle); next state is set every cycle from that cycle's grant; an ls store SHALL go to IDLE.
REQ-018 In FETCH, if_rvalid=1 and if_rdata=ram_rdata exactly one cycle after if_gnt, unless if_flush was high in the grant cycle or is high in the response cycle, in which case if_rvalid=0.
REQ-019 In LOAD, ls_rvalid=1 and ls_rdata=ram_rdata exactly one cycle after ls_gnt; stores SHALL never raise ls_rvalid.
REQ-020 if_rdata/ls_rdata SHALL be 0 when the matching rvalid is 0.
REQ-021 Back-to-back grants SHALL be sustained: a new grant may occur in the same cycle as the previous read's rvalid (full 1 access/cycle throughput).

Reset
REQ-022 While reset_n=0: FSM=IDLE, streak=0, if_gnt=ls_gnt=0, if_rvalid=ls_rvalid=0, ram_en=ram_we=0, ram_addr=ram_wdata=0, rdata outputs 0.
REQ-023 Reset assertion mid-access SHALL drop any pending response; the first cycle after deassertion SHALL arbitrate from IDLE with streak=0.

Verification
REQ-024 Fetch only: if_req=1, if_addr=0x0004 -> ram_en=1, ram_addr=0x0004, if_gnt=1; next cycle ram_rdata=0x00500093 -> if_rvalid=1, if_rdata=0x00500093.
REQ-025 Contention: if_req and ls_req (load 0x0100) held high -> grants ls,ls,ls,if,ls,ls,ls,if; ls_rvalid follows each ls grant by one cycle.
REQ-026 Store: ls_req=1, ls_we=1, ls_addr=0x0200, ls_wdata=0xDEADBEEF -> ram_we=1, ram_wdata=0xDEADBEEF, ls_gnt=1; no ls_rvalid next cycle.
REQ-027 Flush: fetch granted at 0x0008, if_flush=1 in response cycle -> if_rvalid=0; fetch requested with if_flush=1 -> if_gnt=0, ram_en=0.
REQ-028 Reset mid-read: load granted, reset_n low before next edge -> ls_rvalid=0, all outputs 0; after release, fetch at 0x0000 granted first cycle with streak=0.
